// File: rtl/mips_mc_controller_if.sv
// Control bus between the multicycle MIPS controller and its datapath.
//   opcode, func, zero : instruction fields and ALU zero flag, from the datapath
//   reg_dst..reg_write : mux selects and write enables, to the datapath
// master = controller side, slave = datapath side.
interface mips_mc_controller_if;
   logic [5:0] opcode;
   logic [5:0] func;
   logic       zero;
   logic [1:0] reg_dst;
   logic [1:0] mem_to_reg;
   logic       ALU_srcA;
   logic [1:0] ALU_srcB;
   logic [1:0] pc_src;
   logic [2:0] alu_op;
   logic       pc_write_input;
   logic       IorD;
   logic       IR_write;
   logic       mem_read;
   logic       mem_write;
   logic       reg_write;

   modport master (
      input  opcode, func, zero,
      output reg_dst, mem_to_reg, ALU_srcA, ALU_srcB, pc_src, alu_op,
             pc_write_input, IorD, IR_write, mem_read, mem_write, reg_write
   );

   modport slave (
      output opcode, func, zero,
      input  reg_dst, mem_to_reg, ALU_srcA, ALU_srcB, pc_src, alu_op,
             pc_write_input, IorD, IR_write, mem_read, mem_write, reg_write
   );
endinterface

// File: rtl/mips_mc_controller.sv
// Moore control FSM for the multicycle MIPS core.
//   clk     : system clock, rising edge
//   rst     : asynchronous active-low reset
//   bus     : control bus (master side), see mips_mc_controller_if
//   state   : current state code, debug
//   illegal : sticky, set when DECODE meets an undecodable instruction
//   retired : completed-instruction count, wraps
module mips_mc_controller #(
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   mips_mc_controller_if.master bus,
   output logic [3:0]           state,
   output logic                 illegal,
   output logic [CNT_W-1:0]     retired
);

   typedef enum logic [3:0] {
      FETCH     = 4'd0,
      DECODE    = 4'd1,
      MEM_ADDR  = 4'd2,
      MEM_READ  = 4'd3,
      MEM_WB    = 4'd4,
      MEM_WRITE = 4'd5,
      R_EXEC    = 4'd6,
      R_WB      = 4'd7,
      BRANCH    = 4'd8,
      JUMP      = 4'd9,
      JAL       = 4'd10,
      JR        = 4'd11,
      I_EXEC    = 4'd12,
      I_WB      = 4'd13
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] FN_JR    = 6'b001000;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b100;

   typedef struct packed {
      logic [1:0] reg_dst;
      logic [1:0] mem_to_reg;
      logic       src_a;
      logic [1:0] src_b;
      logic [1:0] pc_src;
      logic [2:0] alu_op;
      logic       pc_write;
      logic       iord;
      logic       ir_write;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
   } ctrl_t;

   state_t                 state_q;
   state_t                 nxt;
   ctrl_t                  ctrl_q;
   logic                   branch_q;
   logic                   bne_q;
   logic                   illegal_q;
   logic [CNT_W-1:0]       retired_q;
   logic                   retire;
   logic                   decode_fail;

   function automatic logic is_r_alu(input logic [5:0] f);
      case (f)
         6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: is_r_alu = 1'b1;
         default:                                               is_r_alu = 1'b0;
      endcase
   endfunction

   function automatic logic [2:0] r_alu_op(input logic [5:0] f);
      case (f)
         6'b100010: r_alu_op = ALU_SUB;
         6'b100100: r_alu_op = ALU_AND;
         6'b100101: r_alu_op = ALU_OR;
         6'b101010: r_alu_op = ALU_SLT;
         default:   r_alu_op = ALU_ADD;
      endcase
   endfunction

   // Outputs belonging to state s; opcode/func only refine the ALU op.
   function automatic ctrl_t decode(input state_t s, input logic [5:0] op, input logic [5:0] f);
      ctrl_t c;
      c        = '0;
      c.alu_op = ALU_ADD;
      case (s)
         FETCH: begin
            c.mem_read = 1'b1; c.ir_write = 1'b1; c.src_b = 2'd1; c.pc_write = 1'b1;
         end
         DECODE:    c.src_b = 2'd3;
         MEM_ADDR:  begin c.src_a = 1'b1; c.src_b = 2'd2; end
         MEM_READ:  begin c.mem_read = 1'b1; c.iord = 1'b1; end
         MEM_WB:    begin c.mem_to_reg = 2'd1; c.reg_write = 1'b1; end
         MEM_WRITE: begin c.mem_write = 1'b1; c.iord = 1'b1; end
         R_EXEC:    begin c.src_a = 1'b1; c.alu_op = r_alu_op(f); end
         R_WB:      begin c.reg_dst = 2'd1; c.reg_write = 1'b1; end
         I_EXEC: begin
            c.src_a  = 1'b1;
            c.src_b  = 2'd2;
            c.alu_op = (op == OP_SLTI) ? ALU_SLT : ALU_ADD;
         end
         I_WB:      c.reg_write = 1'b1;
         BRANCH:    begin c.src_a = 1'b1; c.alu_op = ALU_SUB; c.pc_src = 2'd2; end
         JUMP:      begin c.pc_src = 2'd1; c.pc_write = 1'b1; end
         JAL: begin
            c.reg_dst = 2'd2; c.mem_to_reg = 2'd2; c.reg_write = 1'b1;
            c.pc_src  = 2'd1; c.pc_write   = 1'b1;
         end
         JR:        begin c.pc_src = 2'd3; c.pc_write = 1'b1; end
         default:   c = c;
      endcase
      return c;
   endfunction

   always_comb begin
      nxt         = FETCH;
      retire      = 1'b0;
      decode_fail = 1'b0;
      case (state_q)
         FETCH: nxt = DECODE;
         DECODE: begin
            case (bus.opcode)
               OP_RTYPE: begin
                  if (is_r_alu(bus.func))     nxt = R_EXEC;
                  else if (bus.func == FN_JR) nxt = JR;
                  else                        decode_fail = 1'b1;
               end
               OP_LW, OP_SW:    nxt = MEM_ADDR;
               OP_BEQ, OP_BNE:  nxt = BRANCH;
               OP_J:            nxt = JUMP;
               OP_JAL:          nxt = JAL;
               OP_ADDI, OP_SLTI: nxt = I_EXEC;
               default:         decode_fail = 1'b1;
            endcase
         end
         MEM_ADDR: nxt = (bus.opcode == OP_SW) ? MEM_WRITE : MEM_READ;
         MEM_READ: nxt = MEM_WB;
         R_EXEC:   nxt = R_WB;
         I_EXEC:   nxt = I_WB;
         MEM_WB, MEM_WRITE, R_WB, I_WB, BRANCH, JUMP, JAL, JR: retire = 1'b1;
         default:  nxt = FETCH;
      endcase
   end

   // Outputs are registered from the next state, so the reset value is the
   // FETCH decode; the write enables are additionally gated by rst below.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= FETCH;
         ctrl_q    <= decode(FETCH, '0, '0);
         branch_q  <= 1'b0;
         bne_q     <= 1'b0;
         illegal_q <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q  <= nxt;
         ctrl_q   <= decode(nxt, bus.opcode, bus.func);
         branch_q <= (nxt == BRANCH);
         if (nxt == BRANCH) bne_q <= (bus.opcode == OP_BNE);
         if (decode_fail)   illegal_q <= 1'b1;
         if (retire)        retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // zero arrives in the BRANCH cycle itself, so the branch condition is
   // resolved combinationally on top of the registered enable.
   assign bus.pc_write_input = rst & (ctrl_q.pc_write | (branch_q & (bus.zero ^ bne_q)));
   assign bus.IR_write       = rst & ctrl_q.ir_write;
   assign bus.reg_write      = rst & ctrl_q.reg_write;
   assign bus.mem_write      = rst & ctrl_q.mem_write;
   assign bus.mem_read       = ctrl_q.mem_read;
   assign bus.IorD           = ctrl_q.iord;
   assign bus.reg_dst        = ctrl_q.reg_dst;
   assign bus.mem_to_reg     = ctrl_q.mem_to_reg;
   assign bus.ALU_srcA       = ctrl_q.src_a;
   assign bus.ALU_srcB       = ctrl_q.src_b;
   assign bus.pc_src         = ctrl_q.pc_src;
   assign bus.alu_op         = ctrl_q.alu_op;

   assign state   = state_q;
   assign illegal = illegal_q;
   assign retired = retired_q;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Self-checking bench for mips_mc_controller: table of per-cycle vectors
// plus hand sequences for reset behaviour and counter wrap.
module tb_mips_mc_controller;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mips_mc_controller_if bus ();
   mips_mc_controller_if bus_s ();

   logic [3:0]  state, state_s;
   logic        illegal, illegal_s;
   logic [15:0] retired;
   logic [2:0]  retired_s;

   mips_mc_controller #(.CNT_W(16)) dut (
      .clk(clk), .rst(rst), .bus(bus), .state(state), .illegal(illegal), .retired(retired)
   );

   // Narrow-counter instance fed the same instruction stream, used for the wrap check.
   mips_mc_controller #(.CNT_W(3)) dut_s (
      .clk(clk), .rst(rst), .bus(bus_s), .state(state_s), .illegal(illegal_s), .retired(retired_s)
   );
   assign bus_s.opcode = bus.opcode;
   assign bus_s.func   = bus.func;
   assign bus_s.zero   = bus.zero;

   typedef struct packed {
      logic [1:0] rd;
      logic [1:0] m2r;
      logic       sa;
      logic [1:0] sb;
      logic [1:0] ps;
      logic [2:0] aop;
      logic       pcw;
      logic       iord;
      logic       irw;
      logic       mr;
      logic       mw;
      logic       rw;
   } outs_t;

   //                              rd    m2r   sa    sb    ps    aop     pcw   iord  irw   mr    mw    rw
   localparam outs_t O_FETCH  = {2'd0, 2'd0, 1'b0, 2'd1, 2'd0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
   localparam outs_t O_DEC    = {2'd0, 2'd0, 1'b0, 2'd3, 2'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   localparam outs_t O_MADDR  = {2'd0, 2'd0, 1'b1, 2'd2, 2'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   localparam outs_t O_MREAD  = {2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
   localparam outs_t O_MWB    = {2'd0, 2'd1, 1'b0, 2'd0, 2'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   localparam outs_t O_MWRITE = {2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
   localparam outs_t O_RWB    = {2'd1, 2'd0, 1'b0, 2'd0, 2'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   localparam outs_t O_IWB    = {2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   localparam outs_t O_JUMP   = {2'd0, 2'd0, 1'b0, 2'd0, 2'd1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   localparam outs_t O_JAL    = {2'd2, 2'd2, 1'b0, 2'd0, 2'd1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   localparam outs_t O_JR     = {2'd0, 2'd0, 1'b0, 2'd0, 2'd3, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

   function automatic outs_t o_rexec(input logic [2:0] aop);
      return {2'd0, 2'd0, 1'b1, 2'd0, 2'd0, aop, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   endfunction
   function automatic outs_t o_iexec(input logic [2:0] aop);
      return {2'd0, 2'd0, 1'b1, 2'd2, 2'd0, aop, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   endfunction
   function automatic outs_t o_branch(input logic pcw);
      return {2'd0, 2'd0, 1'b1, 2'd0, 2'd2, 3'b001, pcw, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   endfunction

   function automatic outs_t sample();
      return {bus.reg_dst, bus.mem_to_reg, bus.ALU_srcA, bus.ALU_srcB, bus.pc_src, bus.alu_op,
              bus.pc_write_input, bus.IorD, bus.IR_write, bus.mem_read, bus.mem_write, bus.reg_write};
   endfunction

   typedef struct {
      string      name;
      logic [5:0] op;
      logic [5:0] fn;
      logic       z;
      logic [3:0] st;
      outs_t      outs;
      int         ret;
      logic       ill;
   } vec_t;

   vec_t tbl[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input string n, input logic [5:0] op, input logic [5:0] fn, input logic z,
                      input logic [3:0] st, input outs_t o, input int r, input logic il);
      vec_t v;
      v.name = n; v.op = op; v.fn = fn; v.z = z; v.st = st; v.outs = o; v.ret = r; v.ill = il;
      tbl.push_back(v);
   endtask

   // r = retired count once the instruction completes
   task automatic add_r(input string n, input logic [5:0] fn, input logic [2:0] aop, input int r);
      add({n, ".dec"}, 6'b000000, fn, 1'b0, 4'd1, O_DEC,        r - 1, 1'b0);
      add({n, ".ex"},  6'b000000, fn, 1'b0, 4'd6, o_rexec(aop), r - 1, 1'b0);
      add({n, ".wb"},  6'b000000, fn, 1'b0, 4'd7, O_RWB,        r - 1, 1'b0);
      add({n, ".fe"},  6'b000000, fn, 1'b0, 4'd0, O_FETCH,      r,     1'b0);
   endtask

   task automatic add_i(input string n, input logic [5:0] op, input logic [2:0] aop, input int r);
      add({n, ".dec"}, op, 6'b0, 1'b0, 4'd1,  O_DEC,        r - 1, 1'b0);
      add({n, ".ex"},  op, 6'b0, 1'b0, 4'd12, o_iexec(aop), r - 1, 1'b0);
      add({n, ".wb"},  op, 6'b0, 1'b0, 4'd13, O_IWB,        r - 1, 1'b0);
      add({n, ".fe"},  op, 6'b0, 1'b0, 4'd0,  O_FETCH,      r,     1'b0);
   endtask

   task automatic add_b(input string n, input logic [5:0] op, input logic z, input logic pcw, input int r);
      add({n, ".dec"}, op, 6'b0, z, 4'd1, O_DEC,         r - 1, 1'b0);
      add({n, ".br"},  op, 6'b0, z, 4'd8, o_branch(pcw), r - 1, 1'b0);
      add({n, ".fe"},  op, 6'b0, z, 4'd0, O_FETCH,       r,     1'b0);
   endtask

   initial begin
      // ---------------- vector table ----------------
      add_r("add", 6'b100000, 3'b000, 1);
      add_r("sub", 6'b100010, 3'b001, 2);
      add_r("and", 6'b100100, 3'b010, 3);
      add_r("or",  6'b100101, 3'b011, 4);
      add_r("slt", 6'b101010, 3'b100, 5);
      add("lw.dec", 6'b100011, 6'b0, 1'b0, 4'd1, O_DEC,   5, 1'b0);
      add("lw.adr", 6'b100011, 6'b0, 1'b0, 4'd2, O_MADDR, 5, 1'b0);
      add("lw.rd",  6'b100011, 6'b0, 1'b0, 4'd3, O_MREAD, 5, 1'b0);
      add("lw.wb",  6'b100011, 6'b0, 1'b0, 4'd4, O_MWB,   5, 1'b0);
      add("lw.fe",  6'b100011, 6'b0, 1'b0, 4'd0, O_FETCH, 6, 1'b0);
      add("sw.dec", 6'b101011, 6'b0, 1'b0, 4'd1, O_DEC,    6, 1'b0);
      add("sw.adr", 6'b101011, 6'b0, 1'b0, 4'd2, O_MADDR,  6, 1'b0);
      add("sw.wr",  6'b101011, 6'b0, 1'b0, 4'd5, O_MWRITE, 6, 1'b0);
      add("sw.fe",  6'b101011, 6'b0, 1'b0, 4'd0, O_FETCH,  7, 1'b0);
      add_i("addi", 6'b001000, 3'b000, 8);
      add_i("slti", 6'b001010, 3'b100, 9);
      add_b("beq_z1", 6'b000100, 1'b1, 1'b1, 10);
      add_b("beq_z0", 6'b000100, 1'b0, 1'b0, 11);
      add_b("bne_z0", 6'b000101, 1'b0, 1'b1, 12);
      add_b("bne_z1", 6'b000101, 1'b1, 1'b0, 13);
      add("j.dec",   6'b000010, 6'b0, 1'b0, 4'd1,  O_DEC,   13, 1'b0);
      add("j.jmp",   6'b000010, 6'b0, 1'b0, 4'd9,  O_JUMP,  13, 1'b0);
      add("j.fe",    6'b000010, 6'b0, 1'b0, 4'd0,  O_FETCH, 14, 1'b0);
      add("jal.dec", 6'b000011, 6'b0, 1'b0, 4'd1,  O_DEC,   14, 1'b0);
      add("jal.jal", 6'b000011, 6'b0, 1'b0, 4'd10, O_JAL,   14, 1'b0);
      add("jal.fe",  6'b000011, 6'b0, 1'b0, 4'd0,  O_FETCH, 15, 1'b0);
      add("jr.dec",  6'b000000, 6'b001000, 1'b0, 4'd1,  O_DEC,   15, 1'b0);
      add("jr.jr",   6'b000000, 6'b001000, 1'b0, 4'd11, O_JR,    15, 1'b0);
      add("jr.fe",   6'b000000, 6'b001000, 1'b0, 4'd0,  O_FETCH, 16, 1'b0);
      add("ill.dec", 6'b111111, 6'b0, 1'b0, 4'd1,  O_DEC,   16, 1'b0);
      add("ill.fe",  6'b111111, 6'b0, 1'b0, 4'd0,  O_FETCH, 16, 1'b1);
      add("j2.dec",  6'b000010, 6'b0, 1'b0, 4'd1,  O_DEC,   16, 1'b1);
      add("j2.jmp",  6'b000010, 6'b0, 1'b0, 4'd9,  O_JUMP,  16, 1'b1);
      add("j2.fe",   6'b000010, 6'b0, 1'b0, 4'd0,  O_FETCH, 17, 1'b1);

      // ---------------- reset ----------------
      rst        = 1'b0;
      bus.opcode = 6'b111111;
      bus.func   = 6'b0;
      bus.zero   = 1'b0;
      repeat (3) begin
         tick();
         chk("rst.wen", 32'({bus.pc_write_input, bus.IR_write, bus.reg_write, bus.mem_write}), 32'd0);
         chk("rst.state", 32'(state), 32'd0);
      end
      rst = 1'b1;
      #1;
      chk("rel.state",   32'(state),   32'd0);
      chk("rel.retired", 32'(retired), 32'd0);
      chk("rel.illegal", 32'(illegal), 32'd0);
      chk("rel.outs",    32'(sample()), 32'(O_FETCH));

      // ---------------- table ----------------
      foreach (tbl[i]) begin
         bus.opcode = tbl[i].op;
         bus.func   = tbl[i].fn;
         bus.zero   = tbl[i].z;
         tick();
         chk({tbl[i].name, ".state"},   32'(state),    32'(tbl[i].st));
         chk({tbl[i].name, ".outs"},    32'(sample()), 32'(tbl[i].outs));
         chk({tbl[i].name, ".retired"}, 32'(retired),  32'(tbl[i].ret));
         chk({tbl[i].name, ".illegal"}, 32'(illegal),  32'(tbl[i].ill));
      end

      // ---------------- async reset in MEM_READ ----------------
      bus.opcode = 6'b100011;
      bus.func   = 6'b0;
      bus.zero   = 1'b0;
      repeat (3) tick();
      chk("arst.pre_state", 32'(state), 32'd3);
      #2 rst = 1'b0;
      #1;
      chk("arst.state",   32'(state),   32'd0);
      chk("arst.wen",     32'({bus.pc_write_input, bus.IR_write, bus.reg_write, bus.mem_write}), 32'd0);
      chk("arst.illegal", 32'(illegal), 32'd0);
      chk("arst.retired", 32'(retired), 32'd0);
      tick();
      chk("arst.hold_wen", 32'({bus.pc_write_input, bus.IR_write, bus.reg_write, bus.mem_write}), 32'd0);
      rst = 1'b1;
      #1;
      chk("arst.rel_outs", 32'(sample()), 32'(O_FETCH));

      // ---------------- R-type with unknown func ----------------
      bus.opcode = 6'b000000;
      bus.func   = 6'b000001;
      tick();
      tick();
      chk("badfn.state",   32'(state),   32'd0);
      chk("badfn.illegal", 32'(illegal), 32'd1);
      chk("badfn.retired", 32'(retired), 32'd0);

      // ---------------- counter wrap (3-bit instance) ----------------
      bus.opcode = 6'b000010;
      bus.func   = 6'b0;
      for (int k = 1; k <= 8; k++) begin
         repeat (3) tick();
         chk("wrap.retired",   32'(retired),   32'(k));
         chk("wrap.retired_s", 32'(retired_s), 32'(k % 8));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mips_mc_controller.md
Name: mips_mc_controller

Overview:
- Moore-style control FSM for the multicycle MIPS core.
- Consumes opcode, func and zero from the datapath. Drives every datapath mux select and write enable, one state per cycle.
- Adds a retired-instruction counter and a sticky illegal-instruction flag for bring-up and debug.

Parameters:
CNT_W, 16, width of the retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
opcode  input  6  IR[31:26] from datapath
func  input  6  IR[5:0] from datapath
zero  input  1  ALU zero flag, combinational, same cycle
reg_dst  output  2  0=rt, 1=rd, 2=r31
mem_to_reg  output  2  0=alu_reg, 1=MDR, 2=PC
ALU_srcA  output  1  0=PC, 1=A
ALU_srcB  output  2  0=B, 1=const 4, 2=sign-ext imm, 3=imm<<2
pc_src  output  2  0=ALU out, 1=jump target, 2=alu_reg, 3=A
alu_op  output  3  000 add, 001 sub, 010 and, 011 or, 100 slt
pc_write_input  output  1  PC load enable, branch condition already resolved
IorD, IR_write, mem_read, mem_write, reg_write  output  1 each  datapath enables
state  output  4  current state code, debug
illegal  output  1  sticky flag, set on undecodable instruction
retired  output  CNT_W  count of completed instructions, wraps

Behaviour:
- Reset (rst=0, async): state=FETCH, illegal=0, retired=0. While rst=0, pc_write_input, IR_write, reg_write and mem_write are forced to 0.
- Outputs are decoded from the state alone; zero only qualifies pc_write_input in BRANCH.
- Unlisted outputs are 0 in every state; alu_op defaults to add.
- State codes: FETCH0 DECODE1 MEM_ADDR2 MEM_READ3 MEM_WB4 MEM_WRITE5 R_EXEC6 R_WB7 BRANCH8 JUMP9 JAL10 JR11 I_EXEC12 I_WB13. Codes 14 and 15 return to FETCH.
- FETCH: mem_read=1, IorD=0, IR_write=1, srcA=0, srcB=1, add, pc_src=0, pc_write_input=1 -> DECODE.
- DECODE: srcA=0, srcB=3, add; this latches the branch target into alu_reg. Next state by opcode:
  - 000000 with func in {100000, 100010, 100100, 100101, 101010} -> R_EXEC
  - 000000 with func 001000 -> JR
  - 100011 -> MEM_ADDR (lw)
  - 101011 -> MEM_ADDR (sw)
  - 000100 -> BRANCH (beq)
  - 000101 -> BRANCH (bne)
  - 000010 -> JUMP
  - 000011 -> JAL
  - 001000 -> I_EXEC (addi)
  - 001010 -> I_EXEC (slti)
  - anything else -> FETCH, illegal<=1, no retire
- MEM_ADDR: srcA=1, srcB=2, add. Next MEM_READ if lw, MEM_WRITE if sw.
- MEM_READ: mem_read=1, IorD=1 -> MEM_WB.
- MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1 -> FETCH, retire.
- MEM_WRITE: mem_write=1, IorD=1 -> FETCH, retire.
- R_EXEC: srcA=1, srcB=0, alu_op from func (add/sub/and/or/slt) -> R_WB.
- R_WB: reg_dst=1, mem_to_reg=0, reg_write=1 -> FETCH, retire.
- I_EXEC: srcA=1, srcB=2, alu_op add (addi) or slt (slti) -> I_WB.
- I_WB: reg_dst=0, mem_to_reg=0, reg_write=1 -> FETCH, retire.
- BRANCH: srcA=1, srcB=0, sub, pc_src=2. pc_write_input = zero for beq, ~zero for bne -> FETCH, retire.
- JUMP: pc_src=1, pc_write_input=1 -> FETCH, retire.
- JAL: reg_dst=2, mem_to_reg=2, reg_write=1, pc_src=1, pc_write_input=1 -> FETCH, retire. r31 receives PC+4 because PC updates on the same edge.
- JR: pc_src=3, pc_write_input=1 -> FETCH, retire.
- opcode and func are sampled only in DECODE and in states that branch on them. IR holds stable after FETCH, so this is safe.
- retire: retired <= retired+1 on the clock edge leaving a final state; wraps from 2^CNT_W-1 to 0.
- illegal is sticky until reset.
- Reset mid-instruction returns to FETCH immediately and suppresses all writes.
- CPI: lw 5; sw, R-type, addi, slti 4; beq, bne, j, jal, jr 3.

Test Plan:
- Reset held low 3 cycles, release -> state=0, retired=0, illegal=0; no write enables seen during reset. First cycle after release: IR_write=1, pc_write_input=1.
- add (opcode 0, func 100000) -> states 0,1,6,7,0. In state 6 alu_op=000; in state 7 reg_dst=1, reg_write=1. retired becomes 1 after 4 cycles.
- lw (100011) then sw (101011) -> lw visits 0,1,2,3,4 with mem_to_reg=1 in state 4. sw visits 0,1,2,5 with mem_write=1, IorD=1. retired increases by 2 in 9 cycles.
- beq with zero=1, then beq with zero=0, then bne with zero=0 -> pc_write_input in BRANCH is 1, 0, 1; pc_src=2 in all three cases.
- jal (000011) -> in state 10: reg_dst=2, mem_to_reg=2, reg_write=1, pc_src=1. jr (func 001000) -> state 11 with pc_src=3.
- opcode 111111 -> DECODE returns to FETCH, illegal=1, retired unchanged. Assert rst mid-MEM_READ -> state=0 asynchronously. Preload the counter to 0xFFFF and retire one instruction -> retired=0x0000.
